// File: rtl/ring_vc_output_arbiter.sv
// ---------------------------------------------------------------------------
// ring_vc_output_arbiter
//   Output-port arbiter and per-VC packet buffer for one ring-router output.
//   Two requesters share the link.
//     port 0: through traffic. It can have its hop count decremented.
//     port 1: other source.
//   Each virtual channel (VC = data[63]) has one buffer slot.
//   A packet is accepted on VC ~polarity and emitted on VC polarity.
//   Because polarity flips every cycle, a slot never fills and drains in the
//   same cycle.
//
//   Optional feature: define RING_ARB_GRANT_CNT_EN to add the per-port grant
//   counters grant_cnt0 and grant_cnt1.
//
// Ports
//   clk, reset   clock and synchronous active-high reset
//   polarity     toggles each cycle; selects the emitting VC
//   req0/data0   port-0 request and packet; ack0 is the combinational grant
//   req1/data1   port-1 request and packet; ack1 is the combinational grant
//   ro           downstream ready
//   so/dout      registered send strobe and output packet. The packet port
//                is named dout because "do" is a reserved word.
//   grant_cnt0/1 grant counters (only with RING_ARB_GRANT_CNT_EN)
// ---------------------------------------------------------------------------
module ring_vc_output_arbiter #(
   parameter int unsigned WIDTH   = 64,
   parameter int unsigned HOP_DEC = 1,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             polarity,
   input  logic             req0,
   input  logic [WIDTH-1:0] data0,
   output logic             ack0,
   input  logic             req1,
   input  logic [WIDTH-1:0] data1,
   output logic             ack1,
   input  logic             ro,
   output logic             so,
   output logic [WIDTH-1:0] dout
`ifdef RING_ARB_GRANT_CNT_EN
   ,
   output logic [CNT_W-1:0] grant_cnt0,
   output logic [CNT_W-1:0] grant_cnt1
`endif
);

   localparam int unsigned VC_BIT = WIDTH - 1;
   localparam int unsigned HOP_LO = 48;
   localparam int unsigned HOP_HI = 55;
   localparam int unsigned HOP_W  = HOP_HI - HOP_LO + 1;

   // Reject configurations that cannot hold the VC and hop fields.
   if (WIDTH < 64 || CNT_W == 0) begin : g_bad_params
      $error("ring_vc_output_arbiter: WIDTH must be >= 64 and CNT_W >= 1");
   end

   logic             buf_full [2];
   logic [WIDTH-1:0] buf_data [2];
   logic [1:0]       last;

   logic             acc_vc;
   logic             emit_vc;
   logic             elig0;
   logic             elig1;
   logic             win0;
   logic             win1;
   logic             emit_fire;
   logic [WIDTH-1:0] acc_data;

   // Decrement the hop field, saturating at zero.
   function automatic logic [WIDTH-1:0] hop_adjust(input logic [WIDTH-1:0] d);
      logic [HOP_W-1:0] hop;
      hop_adjust = d;
      hop        = d[HOP_HI:HOP_LO];
      if (HOP_DEC != 0 && hop != '0) begin
         hop_adjust[HOP_HI:HOP_LO] = hop - HOP_W'(1);
      end
   endfunction

   // Grant decision and emit qualification
   always_comb begin
      acc_vc    = ~polarity;
      emit_vc   = polarity;
      elig0     = req0 && (data0[VC_BIT] == acc_vc) && !buf_full[acc_vc];
      elig1     = req1 && (data1[VC_BIT] == acc_vc) && !buf_full[acc_vc];
      // On a tie the port that did not win last time on this VC goes first.
      win1      = elig1 && (!elig0 || !last[acc_vc]);
      win0      = elig0 && !win1;
      ack0      = win0 && !reset;
      ack1      = win1 && !reset;
      acc_data  = win0 ? hop_adjust(data0) : data1;
      emit_fire = buf_full[emit_vc] && ro;
   end

   // Control state: occupancy, last winner, output strobe and packet
   always_ff @(posedge clk) begin
      if (reset) begin
         buf_full[0] <= 1'b0;
         buf_full[1] <= 1'b0;
         last        <= 2'b11;
         so          <= 1'b0;
         dout        <= '0;
      end else begin
         so <= emit_fire;
         if (emit_fire) begin
            dout              <= buf_data[emit_vc];
            buf_full[emit_vc] <= 1'b0;
         end
         if (win0 || win1) begin
            buf_full[acc_vc] <= 1'b1;
            last[acc_vc]     <= win1;
         end
      end
   end

   // Payload storage; its content is qualified by buf_full, so it needs no reset.
   always_ff @(posedge clk) begin
      if (!reset && (win0 || win1)) begin
         buf_data[acc_vc] <= acc_data;
      end
   end

`ifdef RING_ARB_GRANT_CNT_EN
   // Free-running grant counters that wrap modulo 2^CNT_W
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else begin
         if (ack0) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
         if (ack1) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_ring_vc_output_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ring_vc_output_arbiter
//   Directed tests for ring_vc_output_arbiter with hand-computed expectations.
//   Inputs change 1 time unit after the rising edge.
//   Acks are sampled 1 unit after the inputs change.
//   Registered outputs are sampled 1 unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_ring_vc_output_arbiter;

   localparam int unsigned WIDTH = 64;
   localparam int unsigned CNT_W = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             polarity;
   logic             req0;
   logic [WIDTH-1:0] data0;
   logic             ack0;
   logic             req1;
   logic [WIDTH-1:0] data1;
   logic             ack1;
   logic             ro;
   logic             so;
   logic [WIDTH-1:0] dout;
`ifdef RING_ARB_GRANT_CNT_EN
   logic [CNT_W-1:0] grant_cnt0;
   logic [CNT_W-1:0] grant_cnt1;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ring_vc_output_arbiter #(.WIDTH(WIDTH), .HOP_DEC(1), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .polarity (polarity),
      .req0     (req0),
      .data0    (data0),
      .ack0     (ack0),
      .req1     (req1),
      .data1    (data1),
      .ack1     (ack1),
      .ro       (ro),
      .so       (so),
      .dout     (dout)
`ifdef RING_ARB_GRANT_CNT_EN
      ,
      .grant_cnt0 (grant_cnt0),
      .grant_cnt1 (grant_cnt1)
`endif
   );

   // Build a packet from its VC, hop count and payload.
   // Bits 62:56 get a fixed tag so that corruption of neighbouring bits is visible.
   function automatic logic [63:0] mk(input logic vc, input logic [7:0] hop, input logic [15:0] pay);
      mk        = '0;
      mk[63]    = vc;
      mk[62:56] = 7'h55;
      mk[55:48] = hop;
      mk[31:16] = 16'hC0DE;
      mk[15:0]  = pay;
   endfunction

   // Advance one clock; polarity flips for the new cycle
   task automatic cycle();
      @(posedge clk);
      #1;
      polarity = ~polarity;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic align(input logic p);
      if (polarity !== p) cycle();
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      req0  = 1'b0;
      req1  = 1'b0;
      ro    = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req0  = 1'b1;
      data0 = mk(1'b1, 8'd3, 16'h0001);
      align(1'b0);
      settle();
      checks++;
      if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack0: got %b want 0", ack0); end
      cycle();
      checks++;
      if (so !== 1'b0) begin errors++; $display("FAIL reset_so: got %b want 0", so); end
      checks++;
      if (dout !== 64'd0) begin errors++; $display("FAIL reset_dout: got %h want 0", dout); end
      req0  = 1'b0;
      reset = 1'b0;
   endtask

   task automatic test_single();
      apply_reset();
      align(1'b0);
      req0  = 1'b1;
      data0 = mk(1'b1, 8'd3, 16'hAAAA);
      settle();
      checks++;
      if (ack0 !== 1'b1) begin errors++; $display("FAIL single_ack0: got %b want 1", ack0); end
      checks++;
      if (ack1 !== 1'b0) begin errors++; $display("FAIL single_ack1: got %b want 0", ack1); end
      cycle();
      req0 = 1'b0;
      checks++;
      if (so !== 1'b0) begin errors++; $display("FAIL single_so_early: got %b want 0", so); end
      cycle();
      checks++;
      if (so !== 1'b1) begin errors++; $display("FAIL single_so: got %b want 1", so); end
      checks++;
      if (dout !== mk(1'b1, 8'd2, 16'hAAAA)) begin
         errors++; $display("FAIL single_dout: got %h want %h", dout, mk(1'b1, 8'd2, 16'hAAAA));
      end
      cycle();
      checks++;
      if (so !== 1'b0) begin errors++; $display("FAIL single_so_drop: got %b want 0", so); end
   endtask

   task automatic test_round_robin();
      // Each port holds its packet until acked. The expected winners are
      // 0,1,0,1, and port-0 packets lose one hop.
      logic [63:0] a_pkt [3];
      logic [63:0] b_pkt [2];
      logic [63:0] exp_do [4];
      logic        exp_w  [4];
      int ia;
      int ib;
      a_pkt[0] = mk(1'b1, 8'd5, 16'hA000);
      a_pkt[1] = mk(1'b1, 8'd6, 16'hA001);
      a_pkt[2] = mk(1'b1, 8'd7, 16'hA002);
      b_pkt[0] = mk(1'b1, 8'd9, 16'hB000);
      b_pkt[1] = mk(1'b1, 8'hFF, 16'hB001);
      exp_w[0] = 1'b0; exp_do[0] = mk(1'b1, 8'd4, 16'hA000);
      exp_w[1] = 1'b1; exp_do[1] = mk(1'b1, 8'd9, 16'hB000);
      exp_w[2] = 1'b0; exp_do[2] = mk(1'b1, 8'd5, 16'hA001);
      exp_w[3] = 1'b1; exp_do[3] = mk(1'b1, 8'hFF, 16'hB001);
      ia = 0;
      ib = 0;
      apply_reset();
      align(1'b0);
      for (int k = 0; k < 4; k++) begin
         req0  = 1'b1;
         req1  = 1'b1;
         data0 = a_pkt[ia];
         data1 = b_pkt[ib];
         settle();
         checks++;
         if (ack0 !== !exp_w[k]) begin errors++; $display("FAIL rr_ack0[%0d]: got %b want %b", k, ack0, !exp_w[k]); end
         checks++;
         if (ack1 !== exp_w[k]) begin errors++; $display("FAIL rr_ack1[%0d]: got %b want %b", k, ack1, exp_w[k]); end
         if (exp_w[k]) ib++; else ia++;
         cycle();
         data0 = a_pkt[ia];
         data1 = b_pkt[(ib > 1) ? 1 : ib];
         settle();
         checks++;
         if ((ack0 | ack1) !== 1'b0) begin errors++; $display("FAIL rr_offvc_ack[%0d]: got %b%b want 00", k, ack0, ack1); end
         cycle();
         checks++;
         if (so !== 1'b1) begin errors++; $display("FAIL rr_so[%0d]: got %b want 1", k, so); end
         checks++;
         if (dout !== exp_do[k]) begin errors++; $display("FAIL rr_dout[%0d]: got %h want %h", k, dout, exp_do[k]); end
      end
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   task automatic test_backpressure();
      apply_reset();
      align(1'b0);
      req0  = 1'b1;
      data0 = mk(1'b1, 8'd9, 16'h0011);
      settle();
      checks++;
      if (ack0 !== 1'b1) begin errors++; $display("FAIL bp_ack0: got %b want 1", ack0); end
      cycle();
      req0  = 1'b0;
      ro    = 1'b0;
      req1  = 1'b1;
      data1 = mk(1'b1, 8'd1, 16'h0022);
      cycle();
      ro = 1'b1;
      settle();
      checks++;
      if (so !== 1'b0) begin errors++; $display("FAIL bp_so_held: got %b want 0", so); end
      checks++;
      if (ack1 !== 1'b0) begin errors++; $display("FAIL bp_ack1_full: got %b want 0", ack1); end
      cycle();
      checks++;
      if (so !== 1'b0) begin errors++; $display("FAIL bp_so_held2: got %b want 0", so); end
      cycle();
      settle();
      checks++;
      if (so !== 1'b1) begin errors++; $display("FAIL bp_so_retry: got %b want 1", so); end
      checks++;
      if (dout !== mk(1'b1, 8'd8, 16'h0011)) begin
         errors++; $display("FAIL bp_dout_retry: got %h want %h", dout, mk(1'b1, 8'd8, 16'h0011));
      end
      checks++;
      if (ack1 !== 1'b1) begin errors++; $display("FAIL bp_ack1_freed: got %b want 1", ack1); end
      cycle();
      req1 = 1'b0;
      cycle();
      checks++;
      if (so !== 1'b1) begin errors++; $display("FAIL bp_so_second: got %b want 1", so); end
      checks++;
      if (dout !== mk(1'b1, 8'd1, 16'h0022)) begin
         errors++; $display("FAIL bp_dout_second: got %h want %h", dout, mk(1'b1, 8'd1, 16'h0022));
      end
   endtask

   task automatic test_wrong_vc();
      apply_reset();
      align(1'b0);
      req1  = 1'b1;
      data1 = mk(1'b0, 8'd4, 16'h0033);
      settle();
      checks++;
      if (ack1 !== 1'b0) begin errors++; $display("FAIL wvc_ack1_wrong: got %b want 0", ack1); end
      cycle();
      settle();
      checks++;
      if (ack1 !== 1'b1) begin errors++; $display("FAIL wvc_ack1_right: got %b want 1", ack1); end
      cycle();
      req1 = 1'b0;
      cycle();
      checks++;
      if (so !== 1'b1) begin errors++; $display("FAIL wvc_so: got %b want 1", so); end
      checks++;
      if (dout !== mk(1'b0, 8'd4, 16'h0033)) begin
         errors++; $display("FAIL wvc_dout: got %h want %h", dout, mk(1'b0, 8'd4, 16'h0033));
      end
   endtask

   task automatic test_hop_zero();
      apply_reset();
      align(1'b0);
      req0  = 1'b1;
      data0 = mk(1'b1, 8'd0, 16'h0044);
      settle();
      checks++;
      if (ack0 !== 1'b1) begin errors++; $display("FAIL hop0_ack0: got %b want 1", ack0); end
      cycle();
      req0 = 1'b0;
      cycle();
      checks++;
      if (so !== 1'b1) begin errors++; $display("FAIL hop0_so: got %b want 1", so); end
      checks++;
      if (dout !== mk(1'b1, 8'd0, 16'h0044)) begin
         errors++; $display("FAIL hop0_dout: got %h want %h", dout, mk(1'b1, 8'd0, 16'h0044));
      end
   endtask

   task automatic test_reset_after_accept();
      apply_reset();
      align(1'b0);
      req0  = 1'b1;
      data0 = mk(1'b1, 8'd2, 16'h0055);
      settle();
      checks++;
      if (ack0 !== 1'b1) begin errors++; $display("FAIL rst_acc_ack0: got %b want 1", ack0); end
      cycle();
      req0  = 1'b0;
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      checks++;
      if (so !== 1'b0) begin errors++; $display("FAIL rst_acc_so: got %b want 0", so); end
      checks++;
      if (dout !== 64'd0) begin errors++; $display("FAIL rst_acc_dout: got %h want 0", dout); end
      cycle();
      cycle();
      checks++;
      if (so !== 1'b0) begin errors++; $display("FAIL rst_acc_no_emit: got %b want 0", so); end
      checks++;
      if (dout !== 64'd0) begin errors++; $display("FAIL rst_acc_dout_hold: got %h want 0", dout); end
   endtask

`ifdef RING_ARB_GRANT_CNT_EN
   task automatic test_grant_cnt();
      apply_reset();
      checks++;
      if (grant_cnt0 !== 16'd0) begin errors++; $display("FAIL cnt0_reset: got %0d want 0", grant_cnt0); end
      for (int i = 0; i < 8; i++) begin
         align(1'b0);
         if (i < 5) begin req0 = 1'b1; data0 = mk(1'b1, 8'd3, 16'(i)); end
         else       begin req1 = 1'b1; data1 = mk(1'b1, 8'd3, 16'(i)); end
         cycle();
         req0 = 1'b0;
         req1 = 1'b0;
      end
      checks++;
      if (grant_cnt0 !== 16'd5) begin errors++; $display("FAIL cnt0: got %0d want 5", grant_cnt0); end
      checks++;
      if (grant_cnt1 !== 16'd3) begin errors++; $display("FAIL cnt1: got %0d want 3", grant_cnt1); end
      apply_reset();
      checks++;
      if (grant_cnt0 !== 16'd0) begin errors++; $display("FAIL cnt0_clear: got %0d want 0", grant_cnt0); end
      checks++;
      if (grant_cnt1 !== 16'd0) begin errors++; $display("FAIL cnt1_clear: got %0d want 0", grant_cnt1); end
   endtask
`endif

   initial begin
      reset    = 1'b1;
      polarity = 1'b0;
      req0     = 1'b0;
      req1     = 1'b0;
      data0    = '0;
      data1    = '0;
      ro       = 1'b1;
      cycle();
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_wrong_vc();
      test_hop_zero();
      test_reset_after_accept();
`ifdef RING_ARB_GRANT_CNT_EN
      test_grant_cnt();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
